// File: rtl/stage4mo.sv
// Memory-operation stage between execute and write-back; issues at most one load/store per instruction.
// Latency: 1 cycle for non-memory ops; memory ops complete the cycle after mem_ack (or abort on timeout).
// Backpressure: stall_out is high for every WAIT cycle, including the ack cycle; upstream holds its outputs.
//
// Ports: execute-side inputs (*_in) and stall_out; data-memory req/ack bus (mem_*);
//        registered write-back bundle (*_out) plus a one-cycle fault_out pulse on memory timeout.
module stage4mo #(
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_in,
    input  logic              flush_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [3:0]        flags_in,
    input  logic [3:0]        reg_waddr_in,
    input  logic              mem_rd_in,
    input  logic              mem_wr_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              enable_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] result_out,
    output logic [3:0]        flags_out,
    output logic [3:0]        reg_waddr_out,
    output logic              fault_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last counter value before abort; only meaningful when TIMEOUT > 0.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_instr;
    logic [3:0]        hold_flags;
    logic [3:0]        hold_waddr;
    logic              hold_load;   // result comes from mem_rdata
    logic              kill;        // flush seen while in flight
    logic [CW-1:0]     cnt;

    logic pass, start, complete, abort;

    assign stall_out = (state == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pass      = 1'b0;
        start     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_in && !flush_in) begin
                    if (mem_rd_in || mem_wr_in) begin
                        start     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
            WAIT: begin
                // An ack in the final timeout cycle takes priority over the abort.
                if (mem_ack) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT > 0 && cnt == TO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            enable_out    <= 1'b0;
            pc_out        <= '0;
            instr_out     <= '0;
            result_out    <= '0;
            flags_out     <= '0;
            reg_waddr_out <= '0;
            fault_out     <= 1'b0;
            hold_pc       <= '0;
            hold_instr    <= '0;
            hold_flags    <= '0;
            hold_waddr    <= '0;
            hold_load     <= 1'b0;
            kill          <= 1'b0;
            cnt           <= '0;
        end else begin
            fault_out <= abort;
            if (pass) begin
                enable_out    <= 1'b1;
                pc_out        <= pc_in;
                instr_out     <= instr_in;
                result_out    <= result_in;
                flags_out     <= flags_in;
                reg_waddr_out <= reg_waddr_in;
            end else if (start) begin
                hold_pc    <= pc_in;
                hold_instr <= instr_in;
                hold_flags <= flags_in;
                hold_waddr <= reg_waddr_in;
                // Both rd and wr set is treated as a store.
                hold_load  <= mem_rd_in & ~mem_wr_in;
                mem_addr   <= result_in;
                mem_wdata  <= store_data_in;
                mem_we     <= mem_wr_in;
                mem_req    <= 1'b1;
                enable_out <= 1'b0;
                kill       <= 1'b0;
                cnt        <= '0;
            end else if (complete) begin
                mem_req       <= 1'b0;
                pc_out        <= hold_pc;
                instr_out     <= hold_instr;
                result_out    <= hold_load ? mem_rdata : mem_addr;
                flags_out     <= hold_flags;
                reg_waddr_out <= hold_waddr;
                enable_out    <= ~(kill | flush_in);
            end else if (abort) begin
                mem_req    <= 1'b0;
                enable_out <= 1'b0;
            end else if (state == WAIT) begin
                // Bus stays untouched; a flush only marks the result as dead.
                cnt        <= cnt + CW'(1);
                enable_out <= 1'b0;
                if (flush_in) kill <= 1'b1;
            end else begin
                enable_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage4mo.sv
module tb_stage4mo;

    localparam int DW = 12;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable_in = 0, flush_in = 0, mem_rd_in = 0, mem_wr_in = 0, mem_ack = 0;
    logic [DW-1:0] pc_in = 0, instr_in = 0, result_in = 0, store_data_in = 0, mem_rdata = 0;
    logic [3:0]    flags_in = 0, reg_waddr_in = 0;
    logic          stall_out, mem_req, mem_we, enable_out, fault_out;
    logic [DW-1:0] mem_addr, mem_wdata, pc_out, instr_out, result_out;
    logic [3:0]    flags_out, reg_waddr_out;

    stage4mo #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .enable_in(enable_in), .flush_in(flush_in),
        .pc_in(pc_in), .instr_in(instr_in), .result_in(result_in),
        .store_data_in(store_data_in), .flags_in(flags_in), .reg_waddr_in(reg_waddr_in),
        .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .enable_out(enable_out), .pc_out(pc_out), .instr_out(instr_out),
        .result_out(result_out), .flags_out(flags_out), .reg_waddr_out(reg_waddr_out),
        .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            fault;
        logic [DW-1:0] pc, instr, result;
        logic [3:0]    flags, waddr;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every valid bundle or fault pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst && (enable_out || fault_out)) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", {30'd0, enable_out, fault_out}, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (e.fault) begin
                    chk("fault_pulse", {31'd0, fault_out}, 32'd1);
                    chk("fault_no_enable", {31'd0, enable_out}, 32'd0);
                end else begin
                    chk("enable_out", {31'd0, enable_out}, 32'd1);
                    chk("no_fault", {31'd0, fault_out}, 32'd0);
                    chk("pc_out", pc_out, e.pc);
                    chk("instr_out", instr_out, e.instr);
                    chk("result_out", result_out, e.result);
                    chk("flags_out", flags_out, e.flags);
                    chk("reg_waddr_out", reg_waddr_out, e.waddr);
                end
            end
        end
    end

    // Drives one instruction and acts as the memory. d = ack cycle within WAIT (1-based,
    // > TO means no ack), fcyc = WAIT cycle carrying a flush (0 = none).
    task automatic issue(input logic en, input logic fl, input logic rd, input logic wr,
                         input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                         input logic [DW-1:0] res, input logic [DW-1:0] sd,
                         input logic [3:0] fg, input logic [3:0] wa,
                         input int d, input int fcyc, input logic [DW-1:0] rdv);
        exp_t e;
        bit   kill;
        kill = 0;
        enable_in = en; flush_in = fl; mem_rd_in = rd; mem_wr_in = wr;
        pc_in = pc; instr_in = ins; result_in = res; store_data_in = sd;
        flags_in = fg; reg_waddr_in = wa;
        e.fault = 0; e.pc = pc; e.instr = ins; e.flags = fg; e.waddr = wa; e.result = res;
        if (!en || fl) begin
            @(posedge clk); #1;
            enable_in = 0; flush_in = 0;
            return;
        end
        if (!(rd || wr)) begin
            expq.push_back(e);
            @(posedge clk); #1;
            enable_in = 0;
            return;
        end
        @(posedge clk); #1;
        for (int k = 1; k <= TO; k++) begin
            chk("stall_in_wait", {31'd0, stall_out}, 32'd1);
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, wr});
            chk("mem_addr", mem_addr, res);
            if (wr) chk("mem_wdata", mem_wdata, sd);
            flush_in = (k == fcyc);
            if (k == fcyc) kill = 1;
            if (k == d) begin
                mem_ack = 1; mem_rdata = rdv;
                if (!kill) begin
                    e.result = wr ? res : rdv;
                    expq.push_back(e);
                end
            end else if (k == TO) begin
                e.fault = 1;
                expq.push_back(e);
            end
            @(posedge clk); #1;
            mem_ack = 0; flush_in = 0; mem_rdata = DW'($urandom);
            if (k == d || k == TO) break;
        end
        chk("stall_after_op", {31'd0, stall_out}, 32'd0);
        chk("req_after_op", {31'd0, mem_req}, 32'd0);
        enable_in = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable_out", {31'd0, enable_out}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall_out", {31'd0, stall_out}, 32'd0);
        chk("rst_fault_out", {31'd0, fault_out}, 32'd0);
        chk("rst_result_out", result_out, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1;
        @(posedge clk); #1;

        // Directed cases.
        issue(1, 0, 0, 0, 12'h100, 12'h111, 12'h123, 12'h000, 4'h3, 4'd5, 0, 0, 12'h0);
        issue(1, 0, 1, 0, 12'h104, 12'h222, 12'h040, 12'h000, 4'h9, 4'd6, 3, 0, 12'hABC);
        issue(1, 0, 0, 1, 12'h108, 12'h333, 12'h010, 12'h5A5, 4'h1, 4'd0, 1, 0, 12'h0);
        issue(1, 0, 1, 0, 12'h10C, 12'h444, 12'h050, 12'h000, 4'h2, 4'd7, 3, 2, 12'h777);
        issue(1, 0, 0, 0, 12'h110, 12'h555, 12'h0AA, 12'h000, 4'h4, 4'd8, 0, 0, 12'h0);
        issue(1, 0, 1, 0, 12'h114, 12'h666, 12'h060, 12'h000, 4'h5, 4'd9, 9, 0, 12'h0);
        issue(1, 0, 1, 0, 12'h118, 12'h777, 12'h070, 12'h000, 4'h6, 4'd1, 4, 0, 12'hDEF);
        issue(1, 0, 1, 1, 12'h11C, 12'h888, 12'h080, 12'h321, 4'h7, 4'd2, 2, 0, 12'hFFF);
        issue(1, 0, 1, 0, 12'h120, 12'h999, 12'h090, 12'h000, 4'h8, 4'd3, 2, 2, 12'h123);
        issue(1, 1, 1, 0, 12'h124, 12'hAAA, 12'h0A0, 12'h000, 4'h8, 4'd3, 1, 0, 12'h0);

        // Reset asserted in the middle of a load.
        enable_in = 1; mem_rd_in = 1; mem_wr_in = 0; result_in = 12'h0B0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0; enable_in = 0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_enable_out", {31'd0, enable_out}, 32'd0);
        chk("midrst_stall_out", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        issue(1, 0, 0, 1, 12'h128, 12'hBBB, 12'h0C0, 12'h456, 4'hA, 4'd4, 2, 0, 12'h0);

        // Randomized traffic with idle-cycle acks that must be ignored.
        for (int n = 0; n < 300; n++) begin
            logic en, fl, rd, wr;
            int   d, fc;
            en = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 9) == 0);
            rd = $urandom_range(0, 1);
            wr = ($urandom_range(0, 2) == 0);
            d  = $urandom_range(1, TO + 2);
            fc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 1) : 0;
            issue(en, fl, rd, wr, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                  4'($urandom), 4'($urandom), d, fc, DW'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                mem_ack = 1; mem_rdata = DW'($urandom);
                @(posedge clk); #1;
                mem_ack = 0;
                chk("idle_ack_no_req", {31'd0, mem_req}, 32'd0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage4mo.md
Name: stage4mo

Overview:
- Memory-operation stage placed directly upstream of the result/write-back stage.
- Takes the execute stage's result, flags, destination register address and instruction.
- Performs at most one data-memory load or store per instruction over a req/ack handshake, stalling upstream while the access is in flight.
- Presents a registered, one-instruction-wide bundle to write-back; for loads, the result field carries memory read data instead of the computed address.

Parameters:
- DATA_W, 12, width of pc, instruction, result, address and memory data.
- TIMEOUT, 16, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable_in  in  1  valid instruction present from execute.
- flush_in  in  1  kill the instruction being accepted or in flight.
- pc_in  in  DATA_W  instruction pc.
- instr_in  in  DATA_W  instruction word.
- result_in  in  DATA_W  ALU result; memory address when mem_rd_in or mem_wr_in is set.
- store_data_in  in  DATA_W  store data.
- flags_in  in  4  flags from execute.
- reg_waddr_in  in  4  destination register.
- mem_rd_in  in  1  instruction is a load.
- mem_wr_in  in  1  instruction is a store.
- stall_out  out  1  upstream must hold its outputs.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- enable_out  out  1  bundle valid to write-back.
- pc_out  out  DATA_W  registered pc.
- instr_out  out  DATA_W  registered instruction word.
- result_out  out  DATA_W  registered result.
- flags_out  out  4  registered flags.
- reg_waddr_out  out  4  registered destination register.
- fault_out  out  1  one-cycle pulse on memory timeout.

Behaviour:
- States: IDLE, WAIT. Reset drives state to IDLE and every output, including all registered bundle fields and mem_* outputs, to 0.
- stall_out = (state == WAIT). It is combinational from state and is 1 in the ack cycle itself.
- IDLE, enable_in=0 or flush_in=1: at the clock edge enable_out <= 0, state stays IDLE, input is ignored.
- IDLE, enable_in=1, no mem op: bundle registers load the inputs and enable_out <= 1. Latency is 1 cycle.
- IDLE, enable_in=1, mem_rd_in or mem_wr_in: at the clock edge:
  - Capture the bundle into the hold registers.
  - mem_addr <= result_in, mem_wdata <= store_data_in, mem_we <= mem_wr_in, mem_req <= 1.
  - enable_out <= 0, state <= WAIT, timeout counter <= 0.
- If both mem_rd_in and mem_wr_in are 1, the access is treated as a store.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until ack.
  - enable_out stays 0.
  - The counter increments each cycle without ack.
- WAIT with mem_ack=1, at the clock edge:
  - mem_req <= 0, state <= IDLE.
  - Bundle outputs load from the hold registers; result_out <= mem_rdata for loads and the address for stores.
  - enable_out <= 1 unless a kill was recorded.
- Memory-op latency: captured at edge N, req visible cycle N+1, ack in cycle K, output valid cycle K+1. Upstream is stalled in cycles N+1..K.
- flush_in during WAIT: the bus transaction is not abandoned and a store still completes. A kill bit is set, so completion produces enable_out=0. A flush in the ack cycle also kills.
- Timeout (TIMEOUT>0): when the counter reaches TIMEOUT-1 with no ack, at that edge mem_req <= 0, state <= IDLE, enable_out <= 0, fault_out <= 1 for one cycle. An ack arriving in that same cycle wins: normal completion, no fault.
- mem_ack while in IDLE is ignored.
- Reset mid-WAIT drops mem_req immediately (asynchronously) and discards the in-flight op.
- flags_out is the captured flags_in; memory ops never modify flags.

Test Plan:
- Non-mem op: enable_in=1, result_in=0x123, reg_waddr_in=5 -> next cycle enable_out=1, result_out=0x123, reg_waddr_out=5, stall_out=0.
- Load with ack after 3 cycles: result_in=0x040, mem_rd_in=1, mem_rdata=0xABC -> mem_req=1 and mem_we=0 with mem_addr=0x040 for 3 cycles, stall_out=1 throughout. Cycle after ack: enable_out=1, result_out=0xABC.
- Store: result_in=0x010, store_data_in=0x5A5, mem_wr_in=1, ack on first req cycle -> mem_we=1, mem_wdata=0x5A5 for one cycle. Next cycle enable_out=1, result_out=0x010.
- Flush during load WAIT, then ack -> mem_req held until ack, enable_out stays 0, state returns to IDLE. The next instruction is accepted the cycle after.
- Timeout: TIMEOUT=4, no ack -> mem_req high 4 cycles, then fault_out=1 for one cycle, enable_out=0, stall_out=0. Repeat with ack in the 4th cycle -> normal completion, fault_out=0.
- Assert rst low during WAIT -> mem_req=0, enable_out=0, stall_out=0 immediately. After release, a new op is accepted normally.
